debounced_input_port: RTL

DEBOUNCED_INPUT_PORT -- requirements
Module: debounced_input_port

---
 rtl/debounced_input_port.sv | 118 +++++++++++
 1 files changed

// File: rtl/debounced_input_port.sv
// Debounced parallel input port with an Avalon-MM slave: stable levels, irq mask, edge capture, raw sync view.
// Define DIP_BOTH_EDGES_EN to capture falling as well as rising edges of the debounced level.
module debounced_input_port #(
    parameter int unsigned WIDTH           = 18,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned ACTIVE_LOW      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port
);

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [31:0]      r_readdata;
    logic             r_irq;

    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_stable_nxt;
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_mask_nxt;
    logic [WIDTH-1:0] w_cap_nxt;
    logic [31:0]      w_rd_mux;
    logic             w_wr;
    logic             w_rd;
    logic             w_unused_wdata;

    assign w_in = (ACTIVE_LOW != 0) ? ~in_port : in_port;

    // Per-channel stability counter: a level must disagree for DEBOUNCE_CYCLES cycles to be accepted
    always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_stable_nxt[i] = r_stable[i];
            w_cnt_nxt[i]    = r_cnt[i];
            if (r_sync2[i] == r_stable[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == CNT_MAX) begin
                w_stable_nxt[i] = r_sync2[i];
                w_cnt_nxt[i]    = '0;
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
        end
    end

`ifdef DIP_BOTH_EDGES_EN
    assign w_edge = w_stable_nxt ^ r_stable;
`else
    assign w_edge = w_stable_nxt & ~r_stable;
`endif

    assign w_wr           = chipselect & write;
    assign w_rd           = chipselect & read;
    assign w_unused_wdata = ^writedata;
    assign w_mask_nxt     = (w_wr && address == 2'd1) ? writedata[WIDTH-1:0] : r_mask;
    assign w_clr          = (w_wr && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
    // A new edge outranks a same-cycle clear of the same bit
    assign w_cap_nxt      = (r_cap & ~w_clr) | w_edge;

    always_comb begin
        w_rd_mux = '0;
        case (address)
            2'd0:    w_rd_mux = 32'(r_stable);
            2'd1:    w_rd_mux = 32'(r_mask);
            2'd2:    w_rd_mux = 32'(r_cap);
            default: w_rd_mux = 32'(r_sync2);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_mask     <= '0;
            r_cap      <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1  <= w_in;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_nxt;
            r_mask   <= w_mask_nxt;
            r_cap    <= w_cap_nxt;
            // irq tracks the capture/mask state committed on this same edge
            r_irq    <= |(w_cap_nxt & w_mask_nxt);
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            if (w_rd) begin
                r_readdata <= w_rd_mux;
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule
